// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin grant of NREQ operand requests onto one
// shared BITS-wide adder, with a single registered response slot.
module shared_adder_arbiter #(
  parameter int unsigned BITS    = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ID_BITS = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_a,
  input  logic [NREQ*BITS-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_BITS-1:0]   rsp_id,
  output logic [BITS-1:0]      rsp_sum,
  output logic                 rsp_carry,
  output logic [15:0]          op_count
);

  localparam int unsigned CNT_W = 16;

  logic               r_rsp_valid;
  logic [ID_BITS-1:0] r_rsp_id;
  logic [BITS-1:0]    r_rsp_sum;
  logic               r_rsp_carry;
  logic [ID_BITS-1:0] r_ptr;
  logic [CNT_W-1:0]   r_op_count;

  logic               w_can_issue;
  logic               w_grant_any;
  logic [ID_BITS-1:0] w_grant_id;
  logic [ID_BITS-1:0] w_sel;
  logic [ID_BITS-1:0] w_ptr_next;
  int unsigned        w_idx;
  logic [BITS-1:0]    w_a_arr [NREQ];
  logic [BITS-1:0]    w_b_arr [NREQ];
  logic [BITS-1:0]    w_a;
  logic [BITS-1:0]    w_b;
  logic [BITS:0]      w_result;

  // Unpack flat operand buses into per-requester arrays
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign w_a_arr[g] = req_a[g*BITS +: BITS];
    assign w_b_arr[g] = req_b[g*BITS +: BITS];
  end

  // Rotating-priority scan starting at r_ptr; first valid requester wins
  always_comb begin
    w_can_issue = !r_rsp_valid || rsp_ready;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_sel       = '0;
    w_idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_sel = ID_BITS'(w_idx);
      if (!w_grant_any && req_valid[w_sel]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_sel;
      end
    end
    // No grant while the slot is blocked or reset is held
    if (!w_can_issue || reset) w_grant_any = 1'b0;
  end

  // One-hot ready toward the granted requester
  always_comb begin
    req_ready = '0;
    if (w_grant_any) req_ready[w_grant_id] = 1'b1;
  end

  // Shared adder on the granted operand pair
  always_comb begin
    w_a        = w_a_arr[w_grant_id];
    w_b        = w_b_arr[w_grant_id];
    w_result   = {1'b0, w_a} + {1'b0, w_b};
    w_ptr_next = (w_grant_id == ID_BITS'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
  end

  // Response slot, round-robin pointer and accepted-op counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_carry <= 1'b0;
      r_ptr       <= '0;
      r_op_count  <= '0;
    end else if (w_grant_any) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant_id;
      r_rsp_sum   <= w_result[BITS-1:0];
      r_rsp_carry <= w_result[BITS];
      r_ptr       <= w_ptr_next;
      r_op_count  <= r_op_count + 1'b1;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_carry = r_rsp_carry;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Self-checking bench for shared_adder_arbiter: cycle model of grant/slot
// state plus a scoreboard of expected results.
module tb_shared_adder_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] res;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_carry;
  logic [15:0] op_count;

  int          n_checks = 0;
  int          n_err    = 0;
  exp_t        sb[$];
  logic        m_valid;
  logic [1:0]  m_ptr;
  logic [15:0] m_cnt;
  logic [3:0]  g_last;
  logic [3:0]  d_last;
  int          order [6] = '{0, 1, 2, 3, 0, 1};
  logic [7:0]  s0;

  shared_adder_arbiter #(.BITS(8), .NREQ(4), .ID_BITS(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .op_count  (op_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Runaway guard
  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_valid = 1'b0;
    m_ptr   = 2'd0;
    m_cnt   = 16'd0;
    g_last  = 4'd0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_id"},    32'(rsp_id),    32'd0);
    check_eq({tag, "_sum"},   32'(rsp_sum),   32'd0);
    check_eq({tag, "_carry"}, 32'(rsp_carry), 32'd0);
    check_eq({tag, "_cnt"},   32'(op_count),  32'd0);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Called at posedge+1; inputs already driven. Checks mid-cycle, then advances.
  task automatic tick();
    logic [3:0] exp_rdy;
    logic [1:0] gi;
    logic [1:0] c;
    logic       found;
    exp_t       fr;
    #4;
    exp_rdy = 4'd0;
    found   = 1'b0;
    gi      = 2'd0;
    if (!reset && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < 4; k++) begin
        c = m_ptr + 2'(k);
        if (!found && req_valid[c]) begin
          found = 1'b1;
          gi    = c;
        end
      end
    end
    if (found) exp_rdy[gi] = 1'b1;
    g_last = exp_rdy;
    d_last = req_ready;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check_eq("op_count",  32'(op_count),  32'(m_cnt));
    if (m_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_underflow got empty exp entry");
      end else begin
        fr = sb[0];
        check_eq("rsp_id",    32'(rsp_id),    32'(fr.id));
        check_eq("rsp_sum",   32'(rsp_sum),   32'(fr.res[7:0]));
        check_eq("rsp_carry", 32'(rsp_carry), 32'(fr.res[8]));
        if (rsp_ready) fr = sb.pop_front();
      end
    end
    if (found) begin
      fr.id  = gi;
      fr.res = {1'b0, req_a[gi*8 +: 8]} + {1'b0, req_b[gi*8 +: 8]};
      sb.push_back(fr);
      m_valid = 1'b1;
      m_ptr   = gi + 2'd1;
      m_cnt   = m_cnt + 16'd1;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_zero_outputs("rst");
    model_clear();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    d_last    = 4'd0;
    model_clear();
    do_reset();

    // Single request from requester 1
    rsp_ready       = 1'b1;
    req_valid       = 4'b0010;
    req_a[15:8]     = 8'h05;
    req_b[15:8]     = 8'h03;
    tick();
    check_eq("t1_grant", 32'(d_last), 32'h2);
    req_valid = 4'b0000;
    check_eq("t1_valid", 32'(rsp_valid), 32'd1);
    check_eq("t1_id",    32'(rsp_id),    32'd1);
    check_eq("t1_sum",   32'(rsp_sum),   32'h08);
    check_eq("t1_carry", 32'(rsp_carry), 32'd0);
    check_eq("t1_cnt",   32'(op_count),  32'd1);

    // Carry and wrap of the sum
    req_valid    = 4'b0100;
    req_a[23:16] = 8'hFF;
    req_b[23:16] = 8'h01;
    tick();
    check_eq("cy1_sum",   32'(rsp_sum),   32'h00);
    check_eq("cy1_carry", 32'(rsp_carry), 32'd1);
    req_b[23:16] = 8'hFF;
    tick();
    req_valid = 4'b0000;
    check_eq("cy2_sum",   32'(rsp_sum),   32'hFE);
    check_eq("cy2_carry", 32'(rsp_carry), 32'd1);
    tick();

    // Round-robin order with all requesters valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(8'h10 * i + 1);
      req_b[i*8 +: 8] = 8'(8'h22 + i);
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      check_eq("rr_grant", 32'(d_last), 32'(1 << order[j]));
      check_eq("rr_id",    32'(rsp_id), 32'(order[j]));
    end

    // Backpressure: slot holds id 2, pointer at 3
    req_valid = 4'b0100;
    tick();
    s0 = 8'(req_a[23:16] + req_b[23:16]);
    req_valid = 4'b1001;
    rsp_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check_eq("bp_ready", 32'(d_last),  32'd0);
      check_eq("bp_id",    32'(rsp_id),  32'd2);
      check_eq("bp_sum",   32'(rsp_sum), 32'(s0));
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_grant", 32'(d_last),    32'h8);
    check_eq("bp_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp_newid", 32'(rsp_id),    32'd3);

    // Random traffic; operands held until granted
    g_last = 4'd0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || g_last[i]) begin
          req_valid[i]    = 1'($urandom_range(0, 1));
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Counter wrap after 65536 grants
    do_reset();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (65535) tick();
    check_eq("wrap_ffff", 32'(op_count), 32'hFFFF);
    tick();
    check_eq("wrap_zero", 32'(op_count), 32'h0000);

    // Async reset mid-cycle while a response is stalled
    req_valid = 4'b0010;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    tick();
    check_eq("ar_pre_valid", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("ar");
    model_clear();
    @(posedge clock);
    #1;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check_eq("ar_grant", 32'(d_last), 32'h1);
    req_valid = 4'b0000;
    tick();
    check_eq("end_valid", 32'(rsp_valid), 32'd0);
    check_eq("end_sb",    32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/shared_adder_arbiter.md
# shared_adder_arbiter

Round-robin arbiter and sequencer that shares one BITS-wide adder (clock, A, B → carry, sum) among NREQ requesters. Each requester presents an operand pair on a valid/ready channel. The block grants at most one request per cycle, computes the sum into a single registered response slot, and returns the result tagged with the requester index on a valid/ready response channel. It sits between the requesting datapath units and the shared adder resource.

## Interface
- BITS, 8, operand/sum width (≥1)
- NREQ, 4, number of requesters (2..16)
- ID_BITS, 2, width of requester index; must equal clog2(NREQ)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NREQ  bit i: requester i presents operands
- req_ready  out  NREQ  bit i: requester i's operands accepted this cycle (at most one bit set)
- req_a  in  NREQ*BITS  operand A of requester i at [i*BITS +: BITS]
- req_b  in  NREQ*BITS  operand B of requester i at [i*BITS +: BITS]
- rsp_valid  out  1  response slot holds a result
- rsp_ready  in  1  consumer accepts the response this cycle
- rsp_id  out  ID_BITS  index of requester that owns the result
- rsp_sum  out  BITS  low BITS of A+B
- rsp_carry  out  1  bit BITS of A+B
- op_count  out  16  number of accepted requests, wraps modulo 2^16

## Operation
- State: response slot (rsp_valid, rsp_id, rsp_sum, rsp_carry), round-robin pointer ptr (ID_BITS), op_count.
- Slot free condition: `can_issue = !rsp_valid || rsp_ready`.
- Grant: if can_issue, pick the first i with req_valid[i] = 1, scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1. req_ready is one-hot on that i and zero otherwise. All req_ready bits are 0 when can_issue = 0 or no req_valid bit is set.
- req_ready depends combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
- On grant i: the slot loads sum/carry = zero-extended req_a[i] + req_b[i] (BITS+1 result), rsp_id = i, and rsp_valid = 1. ptr becomes (i+1) mod NREQ; NREQ-1 wraps to 0. op_count increments, and 0xFFFF wraps to 0x0000.
- On a drain (rsp_valid & rsp_ready) with no grant: rsp_valid = 0. rsp_id, rsp_sum and rsp_carry keep their last values.
- Drain and grant in the same cycle: the new result replaces the old one, and rsp_valid stays 1.
- Stall (rsp_valid & !rsp_ready): rsp_* hold stable, no grant is made, and ptr and op_count hold.
- No request pending: ptr holds.
- Requesters keep req_valid and their operands stable until their req_ready is seen. The block does not check this.

## Timing
- Reset (async assert): rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_carry = 0, ptr = 0, op_count = 0. req_ready = 0 while reset is high.
- Reset mid-operation: a pending response is discarded with no handshake.
- Latency: a request accepted at edge N produces rsp_valid = 1 with its result after edge N, i.e. visible in cycle N+1.
- Throughput: 1 result per cycle while rsp_ready = 1 and requests are pending.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Critical path: NREQ-way rotating priority select, then a BITS-wide add, into the slot registers.

## Test plan
- Reset, then a single request: req_valid = 4'b0010, A = 8'h05, B = 8'h03, rsp_ready = 1 → req_ready = 4'b0010 in cycle 0. In cycle 1: rsp_valid = 1, rsp_id = 1, rsp_sum = 8'h08, rsp_carry = 0, op_count = 1.
- Carry and wrap: A = 8'hFF, B = 8'h01 → rsp_sum = 8'h00, rsp_carry = 1. A = 8'hFF, B = 8'hFF → rsp_sum = 8'hFE, rsp_carry = 1.
- All four requesters valid continuously, rsp_ready = 1, from reset → grant order 0, 1, 2, 3, 0, 1, one per cycle. rsp_id follows the same order, one cycle later.
- Backpressure: slot full with rsp_id = 2, then rsp_ready held 0 for 5 cycles while requesters 0 and 3 are valid → req_ready = 0 and rsp_* stable for all 5 cycles. When rsp_ready rises, requester 3 is granted in that same cycle (ptr = 3), and a new result appears in the next cycle with no bubble.
- Counter wrap: force 65536 grants → op_count goes 0xFFFF → 0x0000.
- Async reset asserted mid-cycle while rsp_valid = 1 and rsp_ready = 0 → rsp_valid and all outputs go to 0 immediately. After release, the first grant uses ptr = 0.
